oversample_filter: RTL and testbench

OVERSAMPLE_FILTER -- requirements
Module: oversample_filter

---
 rtl/oversample_filter_pkg.sv | 17 +
 rtl/oversample_filter.sv | 162 ++++++++++++++++
 tb/tb_oversample_filter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/oversample_filter_pkg.sv
// Shared definitions for the oversampling averager: state encodings and the
// default widths also used by frontpanel_interface and the top level.
package oversample_filter_pkg;

    localparam int DEF_W_DIN   = 18;
    localparam int DEF_W_OSM   = 6;
    localparam int DEF_OSM_MAX = 10;
    localparam int DEF_W_CD    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DELAY = 2'd3
    } osf_state_t;

endpackage

// File: rtl/oversample_filter.sv
// Averages 2^osm consecutive ADC samples into one result, then idles for a
// programmable number of cycles; parameters are double-buffered between sets.
module oversample_filter
    import oversample_filter_pkg::*;
#(
    parameter int W_DIN   = DEF_W_DIN,
    parameter int W_OSM   = DEF_W_OSM,
    parameter int OSM_MAX = DEF_OSM_MAX,
    parameter int W_CD    = DEF_W_CD
) (
    input  logic                    clk50_in,
    input  logic                    rst_n_in,
    input  logic                    data_valid_in,
    input  logic signed [W_DIN-1:0] data_in,
    input  logic                    activate_in,
    input  logic                    update_en_in,
    input  logic                    module_update_in,
    input  logic [W_OSM-1:0]        osm_in,
    input  logic [W_CD-1:0]         cycle_delay_in,
    output logic                    data_valid_out,
    output logic signed [W_DIN-1:0] data_out,
    output logic                    busy_out
);

    localparam int W_ACC = W_DIN + OSM_MAX;
    localparam int W_CNT = OSM_MAX + 1;

    osf_state_t              state;
    osf_state_t              state_nxt;

    logic signed [W_ACC-1:0] sum;
    logic [W_CNT-1:0]        cnt;
    logic [W_CD-1:0]         dly_cnt;

    logic [W_OSM-1:0]        osm_act;
    logic [W_CD-1:0]         cd_act;
    logic [W_OSM-1:0]        osm_shd;
    logic [W_CD-1:0]         cd_shd;
    logic                    pending;

    logic                    copy_now;
    logic [W_OSM-1:0]        osm_use;
    logic [W_CNT-1:0]        set_last;
    logic signed [W_ACC-1:0] sample_ext;
    logic signed [W_ACC-1:0] sum_acc;
    logic                    accept;
    logic                    final_smp;

    function automatic logic [W_OSM-1:0] clamp_osm(input logic [W_OSM-1:0] osm);
        if (osm > W_OSM'(OSM_MAX)) begin
            return W_OSM'(OSM_MAX);
        end
        return osm;
    endfunction

    // Arithmetic shift floors toward -inf; the mean of W_DIN-bit samples always fits W_DIN bits.
    function automatic logic signed [W_DIN-1:0] scale_sum(input logic signed [W_ACC-1:0] acc,
                                                          input logic [W_OSM-1:0]        sh);
        return W_DIN'(acc >>> sh);
    endfunction

    // A pending update lands at a set boundary; it governs the very sample that opens the new set.
    always_comb begin
        copy_now   = pending && ((state == ST_IDLE) || ((state == ST_ACCUM) && (cnt == '0)));
        osm_use    = copy_now ? osm_shd : osm_act;
        set_last   = (W_CNT'(1) << osm_use) - W_CNT'(1);
        sample_ext = {{OSM_MAX{data_in[W_DIN-1]}}, data_in};
        sum_acc    = sum + sample_ext;
        accept     = activate_in && data_valid_in && (state == ST_ACCUM);
        final_smp  = accept && (cnt == set_last);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (final_smp) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_nxt = (cd_act != '0) ? ST_DELAY : ST_ACCUM;
            end
            ST_DELAY: begin
                if (dly_cnt >= cd_act) begin
                    state_nxt = ST_ACCUM;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (!activate_in) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk50_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result is registered on the edge that accepts the final sample, so the
    // strobe is visible during the EMIT cycle.
    always_ff @(posedge clk50_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sum            <= '0;
            cnt            <= '0;
            dly_cnt        <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= final_smp;
            if (final_smp) begin
                data_out <= scale_sum(sum_acc, osm_use);
            end
            if (!activate_in || (state != ST_ACCUM) || final_smp) begin
                sum <= '0;
                cnt <= '0;
            end else if (accept) begin
                sum <= sum_acc;
                cnt <= cnt + W_CNT'(1);
            end
            if (state == ST_EMIT) begin
                dly_cnt <= W_CD'(1);
            end else if (state == ST_DELAY) begin
                dly_cnt <= dly_cnt + W_CD'(1);
            end
        end
    end

    always_ff @(posedge clk50_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            osm_act <= '0;
            cd_act  <= '0;
            osm_shd <= '0;
            cd_shd  <= '0;
            pending <= 1'b0;
        end else begin
            if (copy_now) begin
                osm_act <= osm_shd;
                cd_act  <= cd_shd;
            end
            if (module_update_in && update_en_in) begin
                osm_shd <= clamp_osm(osm_in);
                cd_shd  <= cycle_delay_in;
                pending <= 1'b1;
            end else if (copy_now) begin
                pending <= 1'b0;
            end
        end
    end

    assign busy_out = (state == ST_ACCUM) && (cnt != '0);

endmodule

// File: tb/tb_oversample_filter.sv
// Bench for oversample_filter: directed scenarios plus random traffic, checked
// by a set-level averaging model through an expected-result queue.
module tb_oversample_filter;

    localparam int W_DIN   = 18;
    localparam int W_OSM   = 6;
    localparam int OSM_MAX = 10;
    localparam int W_CD    = 16;

    logic                    clk50_in = 1'b0;
    logic                    rst_n_in;
    logic                    data_valid_in;
    logic signed [W_DIN-1:0] data_in;
    logic                    activate_in;
    logic                    update_en_in;
    logic                    module_update_in;
    logic [W_OSM-1:0]        osm_in;
    logic [W_CD-1:0]         cycle_delay_in;
    logic                    data_valid_out;
    logic signed [W_DIN-1:0] data_out;
    logic                    busy_out;

    always #5 clk50_in = ~clk50_in;

    oversample_filter #(
        .W_DIN  (W_DIN),
        .W_OSM  (W_OSM),
        .OSM_MAX(OSM_MAX),
        .W_CD   (W_CD)
    ) dut (
        .clk50_in        (clk50_in),
        .rst_n_in        (rst_n_in),
        .data_valid_in   (data_valid_in),
        .data_in         (data_in),
        .activate_in     (activate_in),
        .update_en_in    (update_en_in),
        .module_update_in(module_update_in),
        .osm_in          (osm_in),
        .cycle_delay_in  (cycle_delay_in),
        .data_valid_out  (data_valid_out),
        .data_out        (data_out),
        .busy_out        (busy_out)
    );

    typedef struct {
        longint edge_no;
        int     value;
    } exp_t;

    exp_t   exp_q[$];
    int     errors = 0;
    int     checks = 0;

    // Reference model state, expressed in terms of sets and blocked windows.
    longint edge_no   = 0;
    bit     m_run     = 0;
    longint m_next_ok = 0;
    longint m_cnt     = 0;
    longint m_sum     = 0;
    int     m_osm     = 0;
    int     m_cd      = 0;
    int     m_sh_osm  = 0;
    int     m_sh_cd   = 0;
    bit     m_pend    = 0;
    int     m_dout    = 0;
    bit     m_busy    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    function automatic int floor_div(input longint num, input longint den);
        longint q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return int'(q);
    endfunction

    task automatic model_step();
        bit eligible;
        edge_no++;
        if (!rst_n_in) begin
            m_run = 0; m_next_ok = 0; m_cnt = 0; m_sum = 0;
            m_osm = 0; m_cd = 0; m_sh_osm = 0; m_sh_cd = 0; m_pend = 0;
            m_dout = 0; m_busy = 0;
            return;
        end
        eligible = !m_run || ((edge_no >= m_next_ok) && (m_cnt == 0));
        if (eligible && m_pend) begin
            m_osm  = m_sh_osm;
            m_cd   = m_sh_cd;
            m_pend = 0;
        end
        if (module_update_in && update_en_in) begin
            m_sh_osm = (osm_in > OSM_MAX) ? OSM_MAX : int'(osm_in);
            m_sh_cd  = int'(cycle_delay_in);
            m_pend   = 1;
        end
        if (!activate_in) begin
            m_run = 0; m_cnt = 0; m_sum = 0;
        end else if (!m_run) begin
            m_run     = 1;
            m_next_ok = edge_no + 1;
        end else if (data_valid_in && (edge_no >= m_next_ok)) begin
            m_sum += longint'(data_in);
            m_cnt++;
            if (m_cnt == (longint'(1) << m_osm)) begin
                m_dout = floor_div(m_sum, longint'(1) << m_osm);
                exp_q.push_back('{edge_no, m_dout});
                m_sum     = 0;
                m_cnt     = 0;
                m_next_ok = edge_no + 2 + m_cd;
            end
        end
        m_busy = m_run && (m_cnt != 0);
    endtask

    task automatic drive(input bit v, input int d, input bit mu, input bit ue);
        data_valid_in    = v;
        data_in          = W_DIN'(d);
        module_update_in = mu;
        update_en_in     = ue;
        @(posedge clk50_in);
        model_step();
        #3;
    endtask

    task automatic program_params(input int osm, input int cd);
        osm_in         = W_OSM'(osm);
        cycle_delay_in = W_CD'(cd);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 0);
    endtask

    // Monitor: pops the scoreboard whenever a result is due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk50_in);
            #1;
            if ((exp_q.size() > 0) && (exp_q[0].edge_no == edge_no)) begin
                e = exp_q.pop_front();
                chk("strobe_present", int'(data_valid_out), 1);
                chk("strobe_data", int'(data_out), e.value);
            end else begin
                chk("no_strobe", int'(data_valid_out), 0);
            end
            chk("data_out_hold", int'(data_out), m_dout);
            chk("busy", int'(busy_out), int'(m_busy));
        end
    end

    initial begin
        int strobes;
        rst_n_in = 0; activate_in = 0; data_valid_in = 0; data_in = '0;
        update_en_in = 0; module_update_in = 0; osm_in = '0; cycle_delay_in = '0;
        repeat (3) drive(0, 0, 0, 0);
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_valid", int'(data_valid_out), 0);
        chk("reset_busy", int'(busy_out), 0);
        rst_n_in = 1;

        // Plain 4-sample average.
        osm_in = 6'd2; cycle_delay_in = '0;
        drive(0, 0, 1, 1);
        activate_in = 1;
        drive(0, 0, 0, 0);
        drive(1, 4, 0, 0); drive(1, 8, 0, 0); drive(1, 12, 0, 0);
        chk("s_avg4_busy", int'(busy_out), 1);
        drive(1, 16, 0, 0);
        chk("s_avg4_valid", int'(data_valid_out), 1);
        chk("s_avg4_value", int'(data_out), 10);

        // Negative floor, then full-scale 1024-sample set.
        program_params(1, 0);
        drive(1, -3, 0, 0); drive(1, -4, 0, 0);
        chk("s_neg_value", int'(data_out), -4);
        program_params(10, 0);
        repeat (1023) drive(1, 131071, 0, 0);
        chk("s_full_pre", int'(data_valid_out), 0);
        drive(1, 131071, 0, 0);
        chk("s_full_valid", int'(data_valid_out), 1);
        chk("s_full_value", int'(data_out), 131071);

        // Pass-through with dead cycles.
        program_params(0, 3);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, i * 3 - 20, 0, 0);
            strobes += int'(data_valid_out);
        end
        chk("s_cd3_strobes", strobes, 4);

        // Update mid-set, then update coinciding with a final sample.
        program_params(2, 0);
        drive(1, 10, 0, 0); drive(1, 20, 0, 0);
        osm_in = 6'd3;
        drive(1, 30, 1, 1);
        drive(1, 40, 0, 0);
        chk("s_upd_old_set", int'(data_out), 25);
        chk("s_upd_old_valid", int'(data_valid_out), 1);
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) drive(1, i, 0, 0);
        chk("s_upd_new_pre", int'(data_valid_out), 0);
        osm_in = 6'd15;
        drive(1, 8, 1, 1);
        chk("s_upd_new_set", int'(data_out), 4);
        drive(0, 0, 0, 0);
        repeat (1023) drive(1, 5, 0, 0);
        chk("s_clamp_pre", int'(data_valid_out), 0);
        drive(1, 5, 0, 0);
        chk("s_clamp_valid", int'(data_valid_out), 1);

        // Deactivate mid-set, then reset mid-set.
        program_params(2, 0);
        drive(1, 5, 0, 0); drive(1, 5, 0, 0); drive(1, 5, 0, 0);
        activate_in = 0;
        drive(1, 5, 0, 0);
        chk("s_deact_valid", int'(data_valid_out), 0);
        chk("s_deact_busy", int'(busy_out), 0);
        activate_in = 1;
        drive(0, 0, 0, 0);
        repeat (4) drive(1, 1, 0, 0);
        chk("s_react_value", int'(data_out), 1);
        drive(0, 0, 0, 0);
        drive(1, 9, 0, 0); drive(1, 9, 0, 0); drive(1, 9, 0, 0);
        rst_n_in = 0;
        drive(1, 9, 0, 0);
        chk("s_rst_data_out", int'(data_out), 0);
        rst_n_in = 1;
        program_params(2, 0);
        repeat (4) drive(1, 1, 0, 0);
        chk("s_rst_resume", int'(data_out), 1);

        // Update for another channel must be ignored.
        osm_in = '0;
        drive(0, 0, 1, 0);
        drive(1, 2, 0, 0);
        chk("s_noen_pre", int'(data_valid_out), 0);
        drive(1, 4, 0, 0); drive(1, 6, 0, 0); drive(1, 8, 0, 0);
        chk("s_noen_value", int'(data_out), 5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            activate_in    = ($urandom_range(0, 199) != 0);
            rst_n_in       = ($urandom_range(0, 999) != 0);
            osm_in         = W_OSM'($urandom_range(0, 3));
            cycle_delay_in = W_CD'($urandom_range(0, 3));
            drive(($urandom_range(0, 9) < 7), int'($urandom), ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 1) == 1);
        end
        rst_n_in = 1; activate_in = 1;
        repeat (20) drive(0, 0, 0, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
